h75_wr_sched: RTL and testbench
===============================

H75_WR_SCHED -- requirements
Module: h75_wr_sched

Interface
REQ-001 Parameter ADDR_W, default 15, SHALL set the frame-memory write-address width, bank bit included.
REQ-002 Parameter DATA_W, default 32, SHALL set the pixel-word width.
REQ-003 clk  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 resetn  in  1  SHALL be the reset: asynchronous assert, active-low.
REQ-005 a_valid/a_ready/a_addr/a_data  in/out/in/in  1/1/ADDR_W-1/DATA_W  SHALL form requester A, the APB register path.
REQ-006 b_valid/b_ready/b_addr/b_data  in/out/in/in  1/1/ADDR_W-1/DATA_W  SHALL form requester B, the pattern generator.
REQ-007 swap_req  in  1  SHALL be a one-cycle pulse requesting a front/back buffer swap.
REQ-008 frame_sync  in  1  SHALL be a one-cycle pulse from the display engine marking the frame boundary.
REQ-009 swap_done  out  1  SHALL be a one-cycle pulse marking a completed swap.
REQ-010 disp_bank  out  1  SHALL be the bank the display engine reads (front bank).
REQ-011 mem_wr/mem_waddr/mem_data  out  1/ADDR_W/DATA_W  SHALL be the registered frame-memory write port.
REQ-012 swap_pending  out  1  SHALL be high while a swap request is outstanding.

Function
REQ-013 A transfer SHALL occur on a cycle where x_valid and x_ready are both high; a requester SHALL hold its addr/data stable until then.
REQ-014 a_ready and b_ready SHALL be combinational, never both high, and both low while swap_pending is high.
REQ-015 Arbitration SHALL be round-robin: with both valid, the requester not granted last SHALL win; with one valid, that one SHALL win every cycle.
REQ-016 A transfer in cycle N SHALL produce mem_wr=1 in cycle N+1, with mem_data the captured data and mem_waddr = {back_bank, captured addr}.
REQ-017 mem_wr SHALL be 0 in any cycle not preceded by a transfer; mem_waddr and mem_data SHALL hold their last values.
REQ-018 back_bank SHALL always be the inverse of disp_bank.
REQ-019 FSM states SHALL be IDLE and PEND; swap_req in IDLE SHALL move to PEND on the next edge and assert swap_pending.
REQ-020 In PEND, frame_sync with mem_wr=0 SHALL toggle disp_bank, return to IDLE, and pulse swap_done for one cycle, all on the same edge.
REQ-021 In PEND, frame_sync with mem_wr=1 SHALL be ignored; the swap SHALL complete at a later qualifying frame_sync.
REQ-022 swap_req while in PEND SHALL be absorbed, with no second swap.
REQ-023 swap_req and frame_sync in the same IDLE cycle SHALL only enter PEND; the swap SHALL wait for the next frame_sync.
REQ-024 A requester SHALL be granted again on the cycle after the return to IDLE; round-robin history SHALL be preserved across PEND.

Reset
REQ-025 With resetn low: mem_wr=0, mem_waddr=0, mem_data=0, disp_bank=0, swap_done=0, swap_pending=0, FSM=IDLE, last-grant=B so A wins first.
REQ-026 Reset asserted mid-transfer or mid-PEND SHALL discard the captured write and the pending swap; no write SHALL issue after release without a new transfer.

Configuration
REQ-027 Macro H75_WR_SCHED_DBUF_EN SHALL compile double buffering in; REQ-018..024 apply only when it is defined.
REQ-028 Without H75_WR_SCHED_DBUF_EN: disp_bank and the mem_waddr MSB SHALL be 0; swap_pending SHALL stay 0; ready SHALL never be blocked; swap_req SHALL pulse swap_done exactly one cycle later; frame_sync SHALL be ignored.

Verification
REQ-029 A-only, a_valid=1, addrs 0x0000..0x0003, data 0xA0..0xA3 -> four consecutive mem_wr pulses starting one cycle later, mem_waddr 0x4000..0x4003 (DBUF, disp_bank=0).
REQ-030 A and B held valid 6 cycles from reset -> grants A,B,A,B,A,B; mem_data alternates A/B values.
REQ-031 swap_req, then frame_sync 5 cycles later -> readies low for those cycles, disp_bank 0->1, swap_done pulses once, next write goes to mem_waddr MSB 0.
REQ-032 Transfer in cycle N, swap_req in N, frame_sync in N+1 (mem_wr=1) -> no swap; the next frame_sync completes it.
REQ-033 swap_req and frame_sync in the same cycle, then a second swap_req -> PEND; a single swap at the next frame_sync.
REQ-034 resetn pulsed low in PEND with a write captured -> all outputs at reset values, no mem_wr after release; DBUF-off build: swap_req -> swap_done next cycle, disp_bank stays 0.

Source files
------------

// File: rtl/h75_wr_sched.sv
// Frame-memory write scheduler: round-robin arbitration of two requesters onto a registered write port.
// Define H75_WR_SCHED_DBUF_EN to add front/back double buffering with frame-synchronous bank swaps.
module h75_wr_sched #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-2:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-2:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    input  logic              swap_req,
    input  logic              frame_sync,
    output logic              swap_done,
    output logic              disp_bank,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_data,
    output logic              swap_pending
);

    logic grant_a;
    logic grant_b;
    logic xfer_a;
    logic xfer_b;
    logic last_b;
    logic blocked;
    logic back_bank;

    // A wins unless B is also valid and A was served last.
    assign grant_a = a_valid && (!b_valid || last_b);
    assign grant_b = b_valid && !grant_a;
    assign a_ready = grant_a && !blocked;
    assign b_ready = grant_b && !blocked;
    assign xfer_a  = a_valid && a_ready;
    assign xfer_b  = b_valid && b_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_wr    <= 1'b0;
            mem_waddr <= '0;
            mem_data  <= '0;
            last_b    <= 1'b1;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            mem_wr <= xfer_a || xfer_b;
            if (xfer_a) begin
                mem_waddr <= {back_bank, a_addr};
                mem_data  <= a_data;
                last_b    <= 1'b0;
            end else if (xfer_b) begin
                mem_waddr <= {back_bank, b_addr};
                mem_data  <= b_data;
                last_b    <= 1'b1;
            end
        end
    end

`ifdef H75_WR_SCHED_DBUF_EN
    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   disp_nxt;
    logic   done_nxt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            disp_bank <= 1'b0;
            swap_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            disp_bank <= disp_nxt;
            swap_done <= done_nxt;
        end
    end

    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        state_nxt = state;
        disp_nxt  = disp_bank;
        done_nxt  = 1'b0;
        case (state)
            IDLE: if (swap_req) state_nxt = PEND;
            // A write still on the port would land in the bank being flipped to the display.
            PEND: if (frame_sync && !mem_wr) begin
                state_nxt = IDLE;
                disp_nxt  = !disp_bank;
                done_nxt  = 1'b1;
            end
        endcase
    end

    assign swap_pending = (state == PEND);
    assign blocked      = swap_pending;
    assign back_bank    = !disp_bank;
`else
    logic unused_frame_sync;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) swap_done <= 1'b0;
        else         swap_done <= swap_req;
    end

    assign unused_frame_sync = frame_sync;
    assign disp_bank         = 1'b0;
    assign swap_pending      = 1'b0;
    assign blocked           = 1'b0;
    assign back_bank         = 1'b0;
`endif

endmodule

// File: tb/tb_h75_wr_sched.sv
// Scoreboard bench for h75_wr_sched; expectations follow H75_WR_SCHED_DBUF_EN when defined.
module tb_h75_wr_sched;

    localparam int ADDR_W = 15;
    localparam int DATA_W = 32;

    typedef struct {
        int unsigned       cyc;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              a_valid = 1'b0, b_valid = 1'b0;
    logic              a_ready, b_ready;
    logic [ADDR_W-2:0] a_addr = '0, b_addr = '0;
    logic [DATA_W-1:0] a_data = '0, b_data = '0;
    logic              swap_req = 1'b0, frame_sync = 1'b0;
    logic              swap_done, disp_bank, mem_wr, swap_pending;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_data;

    int          n_checks = 0;
    int          n_errors = 0;
    int unsigned cyc = 0;
    logic        exp_disp = 1'b0;
    wr_t         exp_q[$];

    h75_wr_sched #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .resetn(resetn),
        .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
        .swap_req(swap_req), .frame_sync(frame_sync), .swap_done(swap_done),
        .disp_bank(disp_bank), .mem_wr(mem_wr), .mem_waddr(mem_waddr),
        .mem_data(mem_data), .swap_pending(swap_pending)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic back_bank();
`ifdef H75_WR_SCHED_DBUF_EN
        return !exp_disp;
`else
        return 1'b0;
`endif
    endfunction

    // Called in the cycle a transfer is issued; the write must appear one cycle later.
    task automatic expect_wr(input logic [ADDR_W-2:0] addr, input logic [DATA_W-1:0] data);
        wr_t w;
        w.cyc  = cyc + 1;
        w.addr = {back_bank(), addr};
        w.data = data;
        exp_q.push_back(w);
    endtask

    task automatic clear_inputs();
        a_valid = 0; b_valid = 0; swap_req = 0; frame_sync = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        resetn = 0;
        @(negedge clk);
        resetn = 1;
        exp_disp = 0;
    endtask

    task automatic check_ready(input logic ea, input logic eb);
        check("a_ready", a_ready, ea);
        check("b_ready", b_ready, eb);
    endtask

    task automatic check_swap(input logic pend, input logic done);
        check("swap_pending", swap_pending, pend);
        check("swap_done", swap_done, done);
        check("disp_bank", disp_bank, exp_disp);
    endtask

    // Monitor: pops one expectation per presented write and compares address, data and timing.
    initial begin
        wr_t w;
        forever begin
            @(negedge clk);
            if (mem_wr) begin
                check("wr_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    w = exp_q.pop_front();
                    check("wr_cycle", cyc, w.cyc);
                    check("wr_addr", mem_waddr, w.addr);
                    check("wr_data", mem_data, w.data);
                end
            end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
                check("wr_present", mem_wr, 1);
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int ka, kb;

        // Reset values
        @(negedge clk);
        #1;
        check("rst_mem_wr", mem_wr, 0);
        check("rst_waddr", mem_waddr, 0);
        check("rst_data", mem_data, 0);
        check_swap(0, 0);
        resetn = 1;

        // A-only burst
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a_valid = 1; a_addr = 14'(i); a_data = 32'hA0 + 32'(i);
            #1;
            check_ready(1, 0);
            expect_wr(a_addr, a_data);
        end
        @(negedge clk);
        a_valid = 0;
        @(negedge clk);
        check("hold_mem_wr", mem_wr, 0);
        check("hold_waddr", mem_waddr, {back_bank(), 14'h0003});
        check("hold_data", mem_data, 32'hA3);

        // Both valid from reset: A,B,A,B,A,B
        do_reset();
        ka = 0; kb = 0;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            a_valid = 1; a_addr = 14'h100 + 14'(ka); a_data = 32'hAAAA_0000 + 32'(ka);
            b_valid = 1; b_addr = 14'h200 + 14'(kb); b_data = 32'hBBBB_0000 + 32'(kb);
            #1;
            if (j % 2 == 0) begin
                check_ready(1, 0);
                expect_wr(a_addr, a_data);
                ka++;
            end else begin
                check_ready(0, 1);
                expect_wr(b_addr, b_data);
                kb++;
            end
        end
        @(negedge clk);
        clear_inputs();

`ifdef H75_WR_SCHED_DBUF_EN
        // Swap with frame_sync five cycles after the request
        @(negedge clk);
        swap_req = 1;
        #1;
        check_swap(0, 0);
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            swap_req = 0;
            a_valid = 1; a_addr = 14'h300; a_data = 32'hC0;
            b_valid = 1; b_addr = 14'h301; b_data = 32'hC1;
            #1;
            check_ready(0, 0);
            check_swap(1, 0);
        end
        @(negedge clk);
        frame_sync = 1;
        #1;
        check_ready(0, 0);
        @(negedge clk);
        frame_sync = 0;
        exp_disp = 1;
        #1;
        check_swap(0, 1);
        check_ready(1, 0);
        expect_wr(a_addr, a_data);
        @(negedge clk);
        a_valid = 0;
        #1;
        check_swap(0, 0);
        check_ready(0, 1);
        expect_wr(b_addr, b_data);
        @(negedge clk);
        clear_inputs();

        // frame_sync while the write is on the port is ignored
        @(negedge clk);
        a_valid = 1; a_addr = 14'h400; a_data = 32'hD0; swap_req = 1;
        #1;
        check_ready(1, 0);
        expect_wr(a_addr, a_data);
        @(negedge clk);
        clear_inputs();
        frame_sync = 1;
        #1;
        check("sync_with_wr", mem_wr, 1);
        @(negedge clk);
        frame_sync = 0;
        #1;
        check_swap(1, 0);
        @(negedge clk);
        frame_sync = 1;
        @(negedge clk);
        frame_sync = 0;
        exp_disp = 0;
        #1;
        check_swap(0, 1);

        // swap_req with frame_sync in IDLE, then a second swap_req absorbed
        @(negedge clk);
        swap_req = 1; frame_sync = 1;
        @(negedge clk);
        frame_sync = 0;
        #1;
        check_swap(1, 0);
        @(negedge clk);
        swap_req = 0;
        #1;
        check_swap(1, 0);
        @(negedge clk);
        frame_sync = 1;
        @(negedge clk);
        frame_sync = 0;
        exp_disp = 1;
        #1;
        check_swap(0, 1);
        @(negedge clk);
        frame_sync = 1;
        #1;
        check_swap(0, 0);
        @(negedge clk);
        frame_sync = 0;
        #1;
        check_swap(0, 0);
`else
        // Without double buffering: immediate swap_done, no blocking, frame_sync ignored
        @(negedge clk);
        swap_req = 1; frame_sync = 1;
        a_valid = 1; a_addr = 14'h500; a_data = 32'hE0;
        #1;
        check_ready(1, 0);
        check_swap(0, 0);
        expect_wr(a_addr, a_data);
        @(negedge clk);
        clear_inputs();
        #1;
        check_swap(0, 1);
        @(negedge clk);
        frame_sync = 1;
        #1;
        check_swap(0, 0);
        @(negedge clk);
        frame_sync = 0;
        #1;
        check_swap(0, 0);
`endif

        // Reset right after a transfer (and swap request) discards the write and the swap
        @(negedge clk);
        a_valid = 1; a_addr = 14'h600; a_data = 32'hF0; swap_req = 1;
        #1;
        check_ready(1, 0);
        @(posedge clk);
        #1;
        resetn = 0;
        clear_inputs();
        exp_disp = 0;
        @(negedge clk);
        check("rst2_mem_wr", mem_wr, 0);
        check("rst2_waddr", mem_waddr, 0);
        check("rst2_data", mem_data, 0);
        check_swap(0, 0);
        resetn = 1;
        repeat (3) @(negedge clk);
        #1;
        check_swap(0, 0);
        check("post_rst_mem_wr", mem_wr, 0);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
